// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants, index type and range decode for the data memory
package dmem_pkg;

  localparam int DMEM_DEPTH  = 256;
  localparam int DMEM_DATA_W = 32;

  typedef logic [$clog2(DMEM_DEPTH)-1:0] dmem_index_t;

  // True when every address bit above the word-index field is zero.
  function automatic logic dmem_in_range(input logic [63:0] addr, input int unsigned idxW);
    return (addr >> (idxW + 2)) == 64'd0;
  endfunction

endpackage

// File: rtl/dmem_reset_sync.sv
// rtl/dmem_reset_sync.sv - async-assert, sync-deassert qualifier that gates stores after reset
module dmem_reset_sync (
  input  logic clk,
  input  logic resetn,
  output logic storeEn
);

  logic [1:0] syncQ;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      syncQ <= 2'b00;
    end else begin
      syncQ <= {syncQ[0], 1'b1};
    end
  end

  assign storeEn = syncQ[1];

endmodule

// File: rtl/data_memory.sv
// rtl/data_memory.sv - register-based word data memory: clocked stores, combinational loads
module data_memory
  import dmem_pkg::*;
#(
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [ADDR_W-1:0]      address,
  input  logic [DMEM_DATA_W-1:0] writeData,
  input  logic                   memWrite,
  input  logic                   memRead,
  output logic [DMEM_DATA_W-1:0] readData
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [DMEM_DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]       wordIdx;
  logic                   inRange;
  logic                   storeEn;

  dmem_reset_sync uResetSync (
    .clk     (clk),
    .resetn  (resetn),
    .storeEn (storeEn)
  );

  // Bits [1:0] are dropped so misaligned accesses land on the enclosing word.
  assign wordIdx = address[IDX_W+1:2];
  assign inRange = dmem_in_range(64'(address), 32'(IDX_W));

  // Asynchronous clear forces a flop array rather than an inferred RAM.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (storeEn && memWrite && inRange) begin
      mem[wordIdx] <= writeData;
    end
  end

  assign readData = (memRead && inRange) ? mem[wordIdx] : '0;

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - scoreboard bench for data_memory against a word-array reference model
module tb_data_memory;

  localparam int DEPTH = 64;
  localparam int ADDR_W = 32;

  logic        clk;
  logic        resetn;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        memWrite;
  logic        memRead;
  logic [31:0] readData;

  data_memory #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .address   (address),
    .writeData (writeData),
    .memWrite  (memWrite),
    .memRead   (memRead),
    .readData  (readData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } expect_t;

  expect_t     sbQ[$];
  bit          chkPending = 1'b0;
  int          checks = 0;
  int          failures = 0;
  logic [31:0] model [DEPTH];
  int          relEdges = 0;

  function automatic bit inRange(input logic [31:0] a);
    return 64'(a) < 64'(DEPTH) * 64'd4;
  endfunction

  function automatic logic [31:0] modelRead(input bit re, input logic [31:0] a);
    if (!re || !inRange(a)) return 32'h0;
    return model[int'(a >> 2)];
  endfunction

  task automatic clearModel();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    relEdges = 0;
  endtask

  task automatic expectNow(input logic [31:0] a, input logic [31:0] e);
    expect_t x;
    x.addr = a;
    x.exp  = e;
    sbQ.push_back(x);
    chkPending = 1'b1;
  endtask

  // One cycle: drive at posedge+1, expect checked at negedge, model commits at next edge.
  task automatic op(input bit we, input bit re, input logic [31:0] a, input logic [31:0] d);
    memWrite  = we;
    memRead   = re;
    address   = a;
    writeData = d;
    expectNow(a, modelRead(re, a));
    @(posedge clk);
    if (resetn) begin
      if (we && inRange(a) && relEdges >= 2) model[int'(a >> 2)] = d;
      relEdges++;
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (chkPending) begin
      chkPending = 1'b0;
      checks++;
      if (sbQ.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty read=%h", readData);
      end else begin
        expect_t x;
        x = sbQ.pop_front();
        if (readData !== x.exp) begin
          failures++;
          $display("FAIL read addr=%h got=%h expected=%h", x.addr, readData, x.exp);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    resetn = 1'b0; memWrite = 1'b0; memRead = 1'b0; address = '0; writeData = '0;
    clearModel();
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    op(0, 1, 32'h0, 32'h0);
    op(0, 1, 32'h4, 32'h0);
    op(0, 1, 32'hC, 32'h0);
    op(1, 0, 32'h4, 32'hDEADBEEF);
    op(0, 1, 32'h4, 32'h0);
    op(1, 0, 32'h8, 32'h12345678);
    op(0, 1, 32'h8, 32'h0);
    op(0, 1, 32'h4, 32'h0);
    op(0, 1, 32'h6, 32'h0);
    op(0, 0, 32'h4, 32'h0);
    op(1, 0, DEPTH * 4, 32'hCAFEBABE);
    op(0, 1, 32'h0, 32'h0);
    op(0, 1, DEPTH * 4, 32'h0);
    op(0, 1, 32'hFFFF_FFFC, 32'h0);
    op(1, 1, 32'h8, 32'hA5A5A5A5);
    op(0, 1, 32'h8, 32'h0);
    op(1, 1, 32'h10, 32'h1);
    op(1, 1, 32'h10, 32'h2);
    op(0, 1, 32'h13, 32'h0);

    // Reset mid-cycle while a read and a store are presented.
    memRead = 1'b1; memWrite = 1'b1; address = 32'h4; writeData = 32'h5555_AAAA;
    #2 resetn = 1'b0;
    clearModel();
    expectNow(32'h4, 32'h0);
    @(posedge clk);
    #1;
    op(1, 1, 32'h8, 32'h7777_7777);
    op(0, 1, 32'h8, 32'h0);
    resetn = 1'b1;
    op(1, 1, 32'h4, 32'h1111_1111);
    op(1, 1, 32'h4, 32'h2222_2222);
    op(1, 1, 32'h4, 32'h3333_3333);
    op(0, 1, 32'h4, 32'h0);

    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 7))
        0:       a = 32'(DEPTH * 4) + $urandom_range(0, 63);
        1:       a = $urandom | 32'h8000_0000;
        default: a = 32'($urandom_range(0, DEPTH * 4 - 1));
      endcase
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), a, $urandom);
    end

    @(negedge clk);
    #1;
    checks++;
    if (sbQ.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d expected=0", sbQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
